// File: rtl/imm_gen_q_if.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_q_if
// Description : Handshake bundle for imm_gen_q.
//               Producer side: in_valid, in_ready, inst, imm_src, tag_in.
//               Consumer side: out_valid, out_ready, imm_out, tag_out, fmt_err.
//               modport master : the decode/execute environment around the queue
//               modport slave  : the immediate-generator queue itself
// Revision    : 1.0 - initial release
// ============================================================================
interface imm_gen_q_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      inst;
    logic [2:0]       imm_src;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm_out;
    logic [TAG_W-1:0] tag_out;
    logic             fmt_err;

    modport master (
        output in_valid, inst, imm_src, tag_in, out_ready,
        input  in_ready, out_valid, imm_out, tag_out, fmt_err
    );

    modport slave (
        input  in_valid, inst, imm_src, tag_in, out_ready,
        output in_ready, out_valid, imm_out, tag_out, fmt_err
    );
endinterface
`default_nettype wire

// File: rtl/imm_gen_q.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_q
// Description : RISC-V immediate generator (I/S/B/U/J/CSR-zimm) feeding a
//               DEPTH-entry circular queue of {imm, tag, err}.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (empties the queue)
//   flush : synchronous queue clear, wins over push and pop
//   bus   : imm_gen_q_if.slave - input handshake (inst/imm_src/tag_in) and
//           output handshake (imm_out/tag_out/fmt_err)
//   Optional macro IMM_FMT_ERR_EN: stores an error bit for illegal imm_src
//   codes and reports it on fmt_err; otherwise fmt_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_q #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 32
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       flush,
    imm_gen_q_if.slave      bus
);
    localparam int                 c_ptr_w   = $clog2(DEPTH);
    localparam int                 c_cnt_w   = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    // ------------------------------------------------------------------
    // Immediate decode (input side, combinational)
    // ------------------------------------------------------------------
    // Built at 32 bits as a signed value; the sized cast below sign-extends
    // to XLEN. The Z format leaves bit 31 clear, so it comes out zero-extended.
    logic signed [31:0] w_imm32;
    logic [XLEN-1:0]    w_imm;
    logic               w_unused_opcode;

    always_comb begin
        w_imm32 = '0;
        case (bus.imm_src)
            3'b000: w_imm32 = {{20{bus.inst[31]}}, bus.inst[31:20]};
            3'b001: w_imm32 = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
            3'b010: w_imm32 = {{19{bus.inst[31]}}, bus.inst[31], bus.inst[7],
                               bus.inst[30:25], bus.inst[11:8], 1'b0};
            3'b011: w_imm32 = {bus.inst[31:12], 12'b0};
            3'b100: w_imm32 = {{11{bus.inst[31]}}, bus.inst[31], bus.inst[19:12],
                               bus.inst[20], bus.inst[30:21], 1'b0};
            3'b101: w_imm32 = {27'b0, bus.inst[19:15]};
            default: w_imm32 = '0;
        endcase
    end

    assign w_imm           = XLEN'(w_imm32);
    assign w_unused_opcode = ^bus.inst[6:0];

    // ------------------------------------------------------------------
    // Queue control
    // ------------------------------------------------------------------
    logic [c_cnt_w-1:0] count_q, count_d;
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_push;
    logic               w_pop;

    // Ready depends only on the registered count, never on out_ready.
    assign w_in_ready  = (count_q != c_depth);
    assign w_out_valid = (count_q != '0);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + c_ptr_one;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + c_cnt_one;
                2'b01:   count_d = count_q - c_cnt_one;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage (no reset: occupancy is tracked by count_q alone)
    // ------------------------------------------------------------------
    logic [XLEN-1:0]  imm_mem_q [DEPTH];
    logic [XLEN-1:0]  imm_mem_d [DEPTH];
    logic [TAG_W-1:0] tag_mem_q [DEPTH];
    logic [TAG_W-1:0] tag_mem_d [DEPTH];
    logic             w_wr_en;

    assign w_wr_en = w_push && !flush && !rst;

    always_comb begin
        imm_mem_d = imm_mem_q;
        tag_mem_d = tag_mem_q;
        if (w_wr_en) begin
            imm_mem_d[wr_ptr_q] = w_imm;
            tag_mem_d[wr_ptr_q] = bus.tag_in;
        end
    end

    always_ff @(posedge clk) begin
        imm_mem_q <= imm_mem_d;
        tag_mem_q <= tag_mem_d;
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.imm_out   = w_out_valid ? imm_mem_q[rd_ptr_q] : '0;
    assign bus.tag_out   = w_out_valid ? tag_mem_q[rd_ptr_q] : '0;

`ifdef IMM_FMT_ERR_EN
    // Codes 110/111 are the only illegal selects.
    logic w_err;
    logic err_mem_q [DEPTH];
    logic err_mem_d [DEPTH];

    assign w_err = (bus.imm_src[2:1] == 2'b11);

    always_comb begin
        err_mem_d = err_mem_q;
        if (w_wr_en) begin
            err_mem_d[wr_ptr_q] = w_err;
        end
    end

    always_ff @(posedge clk) begin
        err_mem_q <= err_mem_d;
    end

    assign bus.fmt_err = w_out_valid ? err_mem_q[rd_ptr_q] : 1'b0;
`else
    assign bus.fmt_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_q.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_gen_q
// Description : Self-checking bench for imm_gen_q (XLEN=32, DEPTH=2).
//               A recorder pushes expected entries on accepted pushes; a
//               monitor compares the head and handshake flags every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_gen_q;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int TAG_W = 32;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    imm_gen_q_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    imm_gen_q #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;

    entry_t      sbq[$];
    int          model_cnt = 0;
    int          total = 0;
    int          bad = 0;
    bit          mon_en = 1'b0;
    bit          dir_en = 1'b0;
    logic [31:0] dir_imm = '0;

    // Reference immediate: field value gathered with shifts/masks, then
    // interpreted as a two's-complement number of the format's width.
    function automatic logic [31:0] ref_imm(input logic [31:0] i, input logic [2:0] src);
        longint f;
        longint w;
        longint v;
        f = 0;
        w = 32;
        case (src)
            3'd0: begin f = longint'(i >> 20); w = 12; end
            3'd1: begin f = longint'(i >> 25) * 32 + longint'((i >> 7) & 32'h1f); w = 12; end
            3'd2: begin
                f = longint'(i >> 31) * 4096 + longint'((i >> 7) & 32'h1) * 2048
                  + longint'((i >> 25) & 32'h3f) * 32 + longint'((i >> 8) & 32'hf) * 2;
                w = 13;
            end
            3'd3: begin f = longint'(i >> 12) * 4096; w = 32; end
            3'd4: begin
                f = longint'(i >> 31) * 1048576 + longint'((i >> 12) & 32'hff) * 4096
                  + longint'((i >> 20) & 32'h1) * 2048 + longint'((i >> 21) & 32'h3ff) * 2;
                w = 21;
            end
            3'd5: return (i >> 15) & 32'h1f;
            default: return 32'h0;
        endcase
        v = f;
        if (((f >> w) & 1) == 0 && ((f >> (w - 1)) & 1) == 1) v = f - (longint'(1) << w);
        return v[31:0];
    endfunction

    function automatic logic ref_err(input logic [2:0] src);
`ifdef IMM_FMT_ERR_EN
        return (src == 3'd6) || (src == 3'd7);
`else
        return 1'b0 && (src == 3'd7);
`endif
    endfunction

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Recorder: mirrors what the queue commits at each rising edge.
    initial forever begin
        bit     push;
        bit     pop;
        entry_t e;
        @(posedge clk);
        if (rst || flush) begin
            model_cnt = 0;
            sbq.delete();
        end else begin
            push = bus.in_valid && (model_cnt != DEPTH);
            pop  = (model_cnt != 0) && bus.out_ready;
            if (push) begin
                e.imm = dir_en ? dir_imm : ref_imm(bus.inst, bus.imm_src);
                e.tag = bus.tag_in;
                e.err = ref_err(bus.imm_src);
                sbq.push_back(e);
            end
            model_cnt = model_cnt + (push ? 1 : 0) - (pop ? 1 : 0);
        end
    end

    // Monitor: checks flags and head contents away from the clock edge.
    initial forever begin
        bit exp_v;
        @(negedge clk);
        if (mon_en) begin
            exp_v = (model_cnt != 0);
            chk("in_ready", 64'(bus.in_ready), 64'(model_cnt != DEPTH));
            chk("out_valid", 64'(bus.out_valid), 64'(exp_v));
            if (!exp_v) begin
                chk("idle_imm", 64'(bus.imm_out), 64'h0);
                chk("idle_tag", 64'(bus.tag_out), 64'h0);
                chk("idle_err", 64'(bus.fmt_err), 64'h0);
            end else if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty got=out_valid exp=no_entry at %0t", $time);
            end else begin
                chk("head_imm", 64'(bus.imm_out), 64'(sbq[0].imm));
                chk("head_tag", 64'(bus.tag_out), 64'(sbq[0].tag));
                chk("head_err", 64'(bus.fmt_err), 64'(sbq[0].err));
                if (bus.out_ready) void'(sbq.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dir(input logic [31:0] i, input logic [2:0] s,
                            input logic [31:0] t, input logic [31:0] e);
        bus.in_valid = 1'b1;
        bus.inst     = i;
        bus.imm_src  = s;
        bus.tag_in   = t;
        dir_en       = 1'b1;
        dir_imm      = e;
        step();
        bus.in_valid = 1'b0;
        dir_en       = 1'b0;
    endtask

    task automatic idle(input int n, input logic ordy);
        bus.in_valid  = 1'b0;
        bus.out_ready = ordy;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.inst      = '0;
        bus.imm_src   = '0;
        bus.tag_in    = '0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) step();
        rst    = 1'b0;
        mon_en = 1'b1;
        idle(2, 1'b0);

        // Decode sweep with fixed expectations, consumer always ready.
        bus.out_ready = 1'b1;
        push_dir(32'hFFF00093, 3'b000, 32'h100, 32'hFFFFFFFF);
        push_dir(32'h02000423, 3'b001, 32'h104, 32'h00000028);
        // inst[7]=1 in this word sets imm[11], giving -4.
        push_dir(32'hFE000EE3, 3'b010, 32'h108, 32'hFFFFFFFC);
        push_dir(32'hFE000E63, 3'b010, 32'h10C, 32'hFFFFF7FC);
        push_dir(32'h123450B7, 3'b011, 32'h110, 32'h12345000);
        push_dir(32'h0000106F, 3'b100, 32'h114, 32'h00001000);
        push_dir(32'h0010006F, 3'b100, 32'h118, 32'h00000800);
        push_dir(32'h000FD073, 3'b101, 32'h11C, 32'h0000001F);
        push_dir(32'hFFFFFFFF, 3'b110, 32'h120, 32'h00000000);
        push_dir(32'hFFFFFFFF, 3'b111, 32'h124, 32'h00000000);
        idle(3, 1'b1);

        // Fill and backpressure: third push must be refused.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.inst     = $urandom;
            bus.imm_src  = 3'b000;
            bus.tag_in   = 32'(4 * k);
            step();
        end
        idle(4, 1'b1);

        // Simultaneous push/pop holding count at 1.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.inst      = 32'h00500093;
        bus.imm_src   = 3'b000;
        bus.tag_in    = 32'h10;
        step();
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            bus.inst   = $urandom;
            bus.tag_in = 32'h10 + 32'(4 * k);
            step();
        end
        idle(3, 1'b1);

        // Flush together with a push: queue must come out empty.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.in_valid = 1'b1;
            bus.imm_src  = 3'b011;
            bus.inst     = $urandom;
            bus.tag_in   = 32'h200 + 32'(k);
            step();
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.tag_in    = 32'hDEAD;
        flush         = 1'b1;
        step();
        flush = 1'b0;
        idle(3, 1'b1);

        // Randomized traffic, including occasional flush and reset.
        for (int n = 0; n < 800; n++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.inst      = $urandom;
            bus.imm_src   = 3'($urandom_range(0, 7));
            bus.tag_in    = $urandom;
            flush         = ($urandom_range(0, 40) == 0);
            rst           = ($urandom_range(0, 150) == 0);
            step();
        end
        flush = 1'b0;
        rst   = 1'b0;
        idle(4, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
